dcache_direct_mapped: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache between the CPU's byte-wide data port and the block-wide data memory.
- Consumes the CPU's READ, WRITE, ADDRESS and WRITEDATA.
- Returns READDATA and BUSYWAIT to the CPU.
- Issues block reads and writebacks to memory through a level handshake.

---
 rtl/dcache_direct_mapped_pkg.sv | 37 +++
 rtl/dcache_set_array.sv | 63 ++++++
 rtl/dcache_direct_mapped.sv | 118 +++++++++++
 tb/tb_dcache_direct_mapped.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_direct_mapped_pkg.sv
// rtl/dcache_direct_mapped_pkg.sv - shared widths, address slicing and FSM encoding for the data cache
package dcache_direct_mapped_pkg;

   localparam int ADDR_W       = 8;
   localparam int DATA_W       = 8;
   localparam int OFFSET_W     = 2;
   localparam int INDEX_W      = 3;
   localparam int TAG_W        = ADDR_W - INDEX_W - OFFSET_W;
   localparam int BLOCK_W      = 32;
   localparam int SETS         = 1 << INDEX_W;
   localparam int BLOCK_ADDR_W = ADDR_W - OFFSET_W;

   // Bit positions of the fields inside a CPU byte address {tag, index, offset}
   localparam int OFFSET_LSB = 0;
   localparam int INDEX_LSB  = OFFSET_W;
   localparam int TAG_LSB    = OFFSET_W + INDEX_W;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WRITEBACK = 2'd1,
      ST_FETCH     = 2'd2,
      ST_REFILL    = 2'd3
   } state_e;

   function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
      return addr[TAG_LSB +: TAG_W];
   endfunction

   function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
      return addr[INDEX_LSB +: INDEX_W];
   endfunction

   function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] addr);
      return addr[OFFSET_LSB +: OFFSET_W];
   endfunction

endpackage

// File: rtl/dcache_set_array.sv
// rtl/dcache_set_array.sv - valid/dirty/tag/data storage with combinational read and registered write
module dcache_set_array
   import dcache_direct_mapped_pkg::*;
(
   input  logic                clk_i,
   input  logic                resetn_i,
   input  logic [INDEX_W-1:0]  index_i,
   output logic                rd_valid_o,
   output logic                rd_dirty_o,
   output logic [TAG_W-1:0]    rd_tag_o,
   output logic [BLOCK_W-1:0]  rd_block_o,
   input  logic                byte_we_i,
   input  logic [OFFSET_W-1:0] byte_offset_i,
   input  logic [DATA_W-1:0]   byte_data_i,
   input  logic                fill_en_i,
   input  logic [TAG_W-1:0]    fill_tag_i,
   input  logic [BLOCK_W-1:0]  fill_block_i
);

   logic [SETS-1:0]    valid_q, valid_d;
   logic [SETS-1:0]    dirty_q, dirty_d;
   logic [TAG_W-1:0]   tag_q  [SETS];
   logic [BLOCK_W-1:0] data_q [SETS];

   assign rd_valid_o = valid_q[index_i];
   assign rd_dirty_o = dirty_q[index_i];
   assign rd_tag_o   = tag_q[index_i];
   assign rd_block_o = data_q[index_i];

   // Next-state of the status bits: a fill leaves the line clean, a store dirties it
   always_comb begin
      valid_d = valid_q;
      dirty_d = dirty_q;
      if (fill_en_i) begin
         valid_d[index_i] = 1'b1;
         dirty_d[index_i] = 1'b0;
      end else if (byte_we_i) begin
         dirty_d[index_i] = 1'b1;
      end
   end

   // Status bits are the only state cleared by reset
   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end

   // Tag and data arrays keep their contents across reset; only valid gates their use
   always_ff @(posedge clk_i) begin
      if (fill_en_i) begin
         tag_q[index_i]  <= fill_tag_i;
         data_q[index_i] <= fill_block_i;
      end else if (byte_we_i) begin
         data_q[index_i][{byte_offset_i, 3'b000} +: DATA_W] <= byte_data_i;
      end
   end

endmodule

// File: rtl/dcache_direct_mapped.sv
// rtl/dcache_direct_mapped.sv - direct-mapped write-back write-allocate data cache with hit logic and miss FSM
module dcache_direct_mapped
   import dcache_direct_mapped_pkg::*;
(
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic                    READ,
   input  logic                    WRITE,
   input  logic [ADDR_W-1:0]       ADDRESS,
   input  logic [DATA_W-1:0]       WRITEDATA,
   output logic [DATA_W-1:0]       READDATA,
   output logic                    BUSYWAIT,
   output logic                    mem_read,
   output logic                    mem_write,
   output logic [BLOCK_ADDR_W-1:0] mem_address,
   output logic [BLOCK_W-1:0]      mem_writedata,
   input  logic [BLOCK_W-1:0]      mem_readdata,
   input  logic                    mem_busywait
);

   state_e state_q, state_d;
   logic   mem_read_q, mem_read_d;
   logic   mem_write_q, mem_write_d;

   logic [TAG_W-1:0]    req_tag;
   logic [INDEX_W-1:0]  req_index;
   logic [OFFSET_W-1:0] req_offset;

   logic                line_valid;
   logic                line_dirty;
   logic [TAG_W-1:0]    line_tag;
   logic [BLOCK_W-1:0]  line_block;

   logic                request;
   logic                hit;
   logic                byte_we;
   logic                fill_en;

   assign req_tag    = addr_tag(ADDRESS);
   assign req_index  = addr_index(ADDRESS);
   assign req_offset = addr_offset(ADDRESS);

   dcache_set_array u_set_array (
      .clk_i         (CLK),
      .resetn_i      (RESET),
      .index_i       (req_index),
      .rd_valid_o    (line_valid),
      .rd_dirty_o    (line_dirty),
      .rd_tag_o      (line_tag),
      .rd_block_o    (line_block),
      .byte_we_i     (byte_we),
      .byte_offset_i (req_offset),
      .byte_data_i   (WRITEDATA),
      .fill_en_i     (fill_en),
      .fill_tag_i    (req_tag),
      .fill_block_i  (mem_readdata)
   );

   assign request = READ | WRITE;
   assign hit     = line_valid & (line_tag == req_tag);

   assign READDATA      = hit ? line_block[{req_offset, 3'b000} +: DATA_W] : '0;
   assign mem_read      = mem_read_q;
   assign mem_write     = mem_write_q;
   assign mem_writedata = line_block;
   // The victim is written back under its own tag; every other state addresses the requested block
   assign mem_address   = (state_q == ST_WRITEBACK) ? {line_tag, req_index} : {req_tag, req_index};

   // Miss FSM next state, stall and array write strobes; WRITE wins when both requests are high
   always_comb begin
      state_d  = state_q;
      BUSYWAIT = 1'b0;
      byte_we  = 1'b0;
      fill_en  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (request) begin
               if (hit) begin
                  byte_we = WRITE;
               end else begin
                  BUSYWAIT = 1'b1;
                  state_d  = (line_valid & line_dirty) ? ST_WRITEBACK : ST_FETCH;
               end
            end
         end
         ST_WRITEBACK: begin
            BUSYWAIT = 1'b1;
            if (!mem_busywait) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            BUSYWAIT = 1'b1;
            if (!mem_busywait) state_d = ST_REFILL;
         end
         ST_REFILL: begin
            BUSYWAIT = 1'b1;
            fill_en  = 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      mem_read_d  = (state_d == ST_FETCH);
      mem_write_d = (state_d == ST_WRITEBACK);
   end

   // State and memory request registers; reset abandons any transfer in flight
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q     <= ST_IDLE;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
      end
   end

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// tb/tb_dcache_direct_mapped.sv - self-checking bench for dcache_direct_mapped
module tb_dcache_direct_mapped;

   localparam int MEM_LAT = 3;

   logic        CLK;
   logic        RESET;
   logic        READ;
   logic        WRITE;
   logic [7:0]  ADDRESS;
   logic [7:0]  WRITEDATA;
   logic [7:0]  READDATA;
   logic        BUSYWAIT;
   logic        mem_read;
   logic        mem_write;
   logic [5:0]  mem_address;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata;
   logic        mem_busywait;

   int tests_run;
   int tests_failed;

   dcache_direct_mapped dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .READ          (READ),
      .WRITE         (WRITE),
      .ADDRESS       (ADDRESS),
      .WRITEDATA     (WRITEDATA),
      .READDATA      (READDATA),
      .BUSYWAIT      (BUSYWAIT),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_address   (mem_address),
      .mem_writedata (mem_writedata),
      .mem_readdata  (mem_readdata),
      .mem_busywait  (mem_busywait)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Block memory model: each transfer holds mem_busywait high for MEM_LAT-1 cycles
   logic [31:0] mem_model [64];
   int          mem_cnt;

   assign mem_busywait = (mem_read | mem_write) && (mem_cnt < MEM_LAT - 1);
   assign mem_readdata = mem_model[mem_address];

   always @(posedge CLK) begin
      if (!(mem_read | mem_write)) begin
         mem_cnt <= 0;
      end else if (mem_cnt == MEM_LAT - 1) begin
         mem_cnt <= 0;
         if (mem_write) mem_model[mem_address] <= mem_writedata;
      end else begin
         mem_cnt <= mem_cnt + 1;
      end
   end

   // Protocol watch on the CPU side
   logic       busy_prev;
   logic [7:0] addr_prev;
   initial busy_prev = 1'b0;
   always @(posedge CLK) begin
      if (RESET && busy_prev && (READ || WRITE))
         assert (ADDRESS == addr_prev) else $error("ADDRESS changed while stalled");
      busy_prev <= BUSYWAIT & RESET;
      addr_prev <= ADDRESS;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one request that misses and follow it through to the hit that ends the stall
   task automatic miss(input string name, input logic rd, input logic wr,
                       input logic [7:0] addr, input logic [7:0] wdata,
                       input logic [5:0] exp_fetch, input logic exp_wb,
                       input logic [5:0] exp_wb_addr, input logic [31:0] exp_wb_data,
                       input int exp_penalty, input logic [7:0] exp_rdata);
      int busy_cyc, rd_cyc, wr_cyc, both, addr_err, wb_err;
      logic done;
      logic [7:0] got;
      busy_cyc = 0; rd_cyc = 0; wr_cyc = 0; both = 0; addr_err = 0; wb_err = 0;
      done = 1'b0; got = '0;
      READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = wdata;
      for (int c = 0; c < 60; c++) begin
         @(negedge CLK);
         if (mem_read && mem_write) both++;
         if (mem_read) begin
            rd_cyc++;
            if (mem_address !== exp_fetch) addr_err++;
         end
         if (mem_write) begin
            wr_cyc++;
            if (mem_address !== exp_wb_addr || mem_writedata !== exp_wb_data) wb_err++;
         end
         if (!BUSYWAIT) begin
            done = 1'b1;
            got  = READDATA;
            break;
         end
         busy_cyc++;
         @(posedge CLK); #1;
      end
      check({name, "_completed"}, 32'(done), 32'd1);
      check({name, "_penalty"}, busy_cyc, exp_penalty);
      check({name, "_mem_read_cycles"}, rd_cyc, MEM_LAT);
      check({name, "_mem_write_cycles"}, wr_cyc, exp_wb ? MEM_LAT : 0);
      check({name, "_rd_wr_overlap"}, both, 0);
      check({name, "_fetch_addr_errs"}, addr_err, 0);
      check({name, "_writeback_errs"}, wb_err, 0);
      if (rd && !wr) check({name, "_readdata"}, got, exp_rdata);
      @(posedge CLK); #1;
      READ = 1'b0; WRITE = 1'b0;
   endtask

   typedef struct {
      string      name;
      logic       rd;
      logic       wr;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic       exp_busy;
      logic       chk_rdata;
      logic [7:0] exp_rdata;
   } vec_t;

   vec_t vecs [9];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tests_run = 0; tests_failed = 0;

      vecs[0] = '{"hit_rd_27",   1'b1, 1'b0, 8'h27, 8'h00, 1'b0, 1'b1, 8'hDD};
      vecs[1] = '{"hit_rd_25",   1'b1, 1'b0, 8'h25, 8'h00, 1'b0, 1'b1, 8'hBB};
      vecs[2] = '{"hit_wr_24",   1'b0, 1'b1, 8'h24, 8'h5A, 1'b0, 1'b0, 8'h00};
      vecs[3] = '{"hit_rd_24",   1'b1, 1'b0, 8'h24, 8'h00, 1'b0, 1'b1, 8'h5A};
      vecs[4] = '{"hit_rdwr_26", 1'b1, 1'b1, 8'h26, 8'h77, 1'b0, 1'b0, 8'h00};
      vecs[5] = '{"hit_rd_26",   1'b1, 1'b0, 8'h26, 8'h00, 1'b0, 1'b1, 8'h77};
      vecs[6] = '{"idle_miss",   1'b0, 1'b0, 8'h3A, 8'h00, 1'b0, 1'b1, 8'h00};
      vecs[7] = '{"hit_rd_27b",  1'b1, 1'b0, 8'h27, 8'h00, 1'b0, 1'b1, 8'hDD};
      vecs[8] = '{"hit_rd_24b",  1'b1, 1'b0, 8'h24, 8'h00, 1'b0, 1'b1, 8'h5A};

      for (int i = 0; i < 64; i++) mem_model[i] = {8'(i), 8'(i), 8'(i), 8'(i)};
      mem_model[6'h09] = 32'hDDCCBBAA;
      mem_model[6'h29] = 32'h44332211;
      mem_model[6'h04] = 32'h87654321;
      mem_model[6'h24] = 32'hCAFEBABE;
      mem_model[6'h0E] = 32'h00F1E200;

      READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'h00; WRITEDATA = 8'h00;
      RESET = 1'b0;
      repeat (2) @(posedge CLK);
      #1 RESET = 1'b1;
      @(negedge CLK);
      check("reset_busywait", BUSYWAIT, 1'b0);
      check("reset_mem_read", mem_read, 1'b0);
      check("reset_mem_write", mem_write, 1'b0);
      check("reset_readdata", READDATA, 8'h00);
      @(posedge CLK); #1;

      miss("cold_rd_25", 1'b1, 1'b0, 8'h25, 8'h00, 6'h09, 1'b0, 6'h00, 32'h0, 5, 8'hBB);

      for (int i = 0; i < 9; i++) begin
         READ = vecs[i].rd; WRITE = vecs[i].wr;
         ADDRESS = vecs[i].addr; WRITEDATA = vecs[i].wdata;
         @(negedge CLK);
         check({vecs[i].name, "_busywait"}, BUSYWAIT, vecs[i].exp_busy);
         check({vecs[i].name, "_mem_req"}, {mem_read, mem_write}, 2'b00);
         if (vecs[i].chk_rdata) check({vecs[i].name, "_readdata"}, READDATA, vecs[i].exp_rdata);
         @(posedge CLK); #1;
      end
      READ = 1'b0; WRITE = 1'b0;
      check("dirty_set1", dut.u_set_array.dirty_q[1], 1'b1);

      miss("dirty_evict_a4", 1'b1, 1'b0, 8'hA4, 8'h00, 6'h29, 1'b1, 6'h09, 32'hDD77BB5A, 8, 8'h11);
      check("writeback_landed", mem_model[6'h09], 32'hDD77BB5A);

      miss("clean_invalid_13", 1'b1, 1'b0, 8'h13, 8'h00, 6'h04, 1'b0, 6'h00, 32'h0, 5, 8'h87);
      miss("clean_valid_93", 1'b1, 1'b0, 8'h93, 8'h00, 6'h24, 1'b0, 6'h00, 32'h0, 5, 8'hCA);

      // Dirty set 1 with a write hit, then reset in the middle of a fetch
      READ = 1'b0; WRITE = 1'b1; ADDRESS = 8'hA5; WRITEDATA = 8'h99;
      @(negedge CLK);
      check("hit_wr_a5_busywait", BUSYWAIT, 1'b0);
      @(posedge CLK); #1;
      WRITE = 1'b0; READ = 1'b1; ADDRESS = 8'h3A;
      begin
         logic seen;
         seen = 1'b0;
         for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (mem_read) begin
               seen = 1'b1;
               break;
            end
         end
         check("rst_fetch_seen", seen, 1'b1);
      end
      RESET = 1'b0; READ = 1'b0;
      @(negedge CLK);
      check("rst_fetch_mem_read", mem_read, 1'b0);
      check("rst_fetch_mem_write", mem_write, 1'b0);
      check("rst_fetch_busywait", BUSYWAIT, 1'b0);
      RESET = 1'b1;
      @(posedge CLK); #1;

      miss("after_rst_3a", 1'b1, 1'b0, 8'h3A, 8'h00, 6'h0E, 1'b0, 6'h00, 32'h0, 5, 8'hF1);
      miss("after_rst_a5", 1'b1, 1'b0, 8'hA5, 8'h00, 6'h29, 1'b0, 6'h00, 32'h0, 5, 8'h22);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
